// File: rtl/adat_rx_resync_scheduler.sv
// Round-robin resync sequencer for side-by-side ADAT receive channels.
// Define ADAT_RESYNC_WATCHDOG_EN to add run supervision, retries and fault_o.
module adat_rx_resync_scheduler #(
  parameter int NUM_CHANNELS   = 4,
  parameter int SETTLE_CYCLES  = 256,
  parameter int TIMEOUT_CYCLES = 12288,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NUM_CHANNELS-1:0] locked_i,
  input  logic [NUM_CHANNELS-1:0] running_i,
  input  logic                    resync_all_i,
  output logic [NUM_CHANNELS-1:0] resync_req_o,
  output logic                    busy_o,
  output logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] active_ch_o,
  output logic [NUM_CHANNELS-1:0] fault_o
);

  localparam int AW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16 || SETTLE_CYCLES < 1 ||
      TIMEOUT_CYCLES < 1 || MAX_RETRIES < 0) begin : g_bad_cfg
    $error("adat_rx_resync_scheduler: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, PULSE, WAIT_RUN, SETTLE} state_e;

  state_e                  state_q, state_d;
  logic [NUM_CHANNELS-1:0] pending_q, pending_d;
  logic [NUM_CHANNELS-1:0] lock_q, run_q;
  logic [NUM_CHANNELS-1:0] req_q, req_d;
  logic [AW-1:0]           active_ch_q, active_ch_d;
  logic [SW-1:0]           settle_cnt_q, settle_cnt_d;
  logic                    busy_q, busy_d;
  logic [NUM_CHANNELS-1:0] lock_rise, run_fall, pend_set, pend_clr, eligible;
  int                      idx;

`ifdef ADAT_RESYNC_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  logic [TW-1:0]           tmo_cnt_q, tmo_cnt_d;
  logic [RW-1:0]           retry_q, retry_d;
  logic [NUM_CHANNELS-1:0] fault_q, fault_d;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    lock_rise    = locked_i & ~lock_q;
    run_fall     = run_q & ~running_i & locked_i;
    pend_set     = lock_rise | run_fall | {NUM_CHANNELS{resync_all_i}};
    eligible     = pending_q & locked_i;
    pend_clr     = '0;
    req_d        = '0;
    state_d      = state_q;
    active_ch_d  = active_ch_q;
    settle_cnt_d = settle_cnt_q;
    idx          = 0;
`ifdef ADAT_RESYNC_WATCHDOG_EN
    tmo_cnt_d    = tmo_cnt_q;
    retry_d      = retry_q;
    fault_d      = fault_q & ~lock_rise;
`endif

    case (state_q)
      IDLE: begin
        if (|eligible) begin
          // Walk offsets high-to-low so the nearest channel above the last grant wins.
          for (int off = NUM_CHANNELS; off >= 1; off--) begin
            idx = int'(active_ch_q) + off;
            if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
            if (eligible[AW'(idx)]) active_ch_d = AW'(idx);
          end
          req_d[active_ch_d] = 1'b1;
          state_d            = PULSE;
`ifdef ADAT_RESYNC_WATCHDOG_EN
          retry_d            = '0;
`endif
        end
      end

      PULSE: begin
        pend_clr[active_ch_q] = 1'b1;
`ifdef ADAT_RESYNC_WATCHDOG_EN
        tmo_cnt_d    = TW'(1);
        state_d      = WAIT_RUN;
`else
        settle_cnt_d = SW'(1);
        state_d      = SETTLE;
`endif
      end

`ifdef ADAT_RESYNC_WATCHDOG_EN
      WAIT_RUN: begin
        if (!locked_i[active_ch_q]) begin
          settle_cnt_d = SW'(1);
          state_d      = SETTLE;
        end else if (running_i[active_ch_q]) begin
          retry_d      = '0;
          settle_cnt_d = SW'(1);
          state_d      = SETTLE;
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES)) begin
          if (retry_q < RW'(MAX_RETRIES)) begin
            retry_d            = retry_q + RW'(1);
            req_d[active_ch_q] = 1'b1;
            state_d            = PULSE;
          end else begin
            fault_d[active_ch_q] = 1'b1;
            settle_cnt_d         = SW'(1);
            state_d              = SETTLE;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
`endif

      SETTLE: begin
        if (settle_cnt_q >= SW'(SETTLE_CYCLES)) state_d = IDLE;
        else settle_cnt_d = settle_cnt_q + SW'(1);
      end

      default: state_d = IDLE;
    endcase

    // A set arriving as the grant retires wins over the clear; lock loss wins over both.
    pending_d = ((pending_q & ~pend_clr) | pend_set) & locked_i;
    // NOTE: busy is registered from next-state values so it lines up with state_q.
    busy_d    = (state_d != IDLE) || (|pending_d);
  end

  // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      lock_q       <= '0;
      run_q        <= '0;
      req_q        <= '0;
      busy_q       <= 1'b0;
      active_ch_q  <= AW'(NUM_CHANNELS - 1);
      settle_cnt_q <= '0;
`ifdef ADAT_RESYNC_WATCHDOG_EN
      tmo_cnt_q    <= '0;
      retry_q      <= '0;
      fault_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      lock_q       <= locked_i;
      run_q        <= running_i;
      req_q        <= req_d;
      busy_q       <= busy_d;
      active_ch_q  <= active_ch_d;
      settle_cnt_q <= settle_cnt_d;
`ifdef ADAT_RESYNC_WATCHDOG_EN
      tmo_cnt_q    <= tmo_cnt_d;
      retry_q      <= retry_d;
      fault_q      <= fault_d;
`endif
    end
  end

  assign resync_req_o = req_q;
  assign busy_o       = busy_q;
  assign active_ch_o  = active_ch_q;
`ifdef ADAT_RESYNC_WATCHDOG_EN
  assign fault_o      = fault_q;
`else
  assign fault_o      = '0;
`endif

endmodule

// File: tb/tb_adat_rx_resync_scheduler.sv
// Scoreboard bench for adat_rx_resync_scheduler; expected pulses are queued when
// stimulus is applied and matched against resync_req_o on falling clock edges.
module tb_adat_rx_resync_scheduler;

  localparam int NCH     = 4;
  localparam int SETTLE  = 8;
  localparam int TMO     = 16;
  localparam int RETRIES = 3;
`ifdef ADAT_RESYNC_WATCHDOG_EN
  localparam int SP = SETTLE + 3;
`else
  localparam int SP = SETTLE + 2;
`endif

  logic           clk = 1'b0;
  logic           reset_i;
  logic [NCH-1:0] locked_i;
  logic [NCH-1:0] running_i;
  logic           resync_all_i;
  logic [NCH-1:0] resync_req_o;
  logic           busy_o;
  logic [1:0]     active_ch_o;
  logic [NCH-1:0] fault_o;

  typedef struct {
    int ch;
    int cyc;
  } pulse_t;

  pulse_t sb[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;

  adat_rx_resync_scheduler #(
    .NUM_CHANNELS  (NCH),
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRIES   (RETRIES)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .locked_i    (locked_i),
    .running_i   (running_i),
    .resync_all_i(resync_all_i),
    .resync_req_o(resync_req_o),
    .busy_o      (busy_o),
    .active_ch_o (active_ch_o),
    .fault_o     (fault_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int ch, input int at);
    pulse_t p;
    p.ch  = ch;
    p.cyc = at;
    sb.push_back(p);
  endtask

  // Advance on falling edges up to cycle end_cyc, matching pulses against the scoreboard.
  task automatic run_until(input int end_cyc);
    int             guard;
    pulse_t         e;
    logic [NCH-1:0] oh;
    guard = 0;
    while (cyc < end_cyc && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (resync_req_o !== '0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d got=%b expected none", cyc, resync_req_o);
        end else begin
          e = sb.pop_front();
          oh = '0;
          oh[e.ch] = 1'b1;
          if (resync_req_o !== oh || cyc != e.cyc) begin
            errors++;
            $display("FAIL pulse got=%b@%0d expected=%b@%0d", resync_req_o, cyc, oh, e.cyc);
          end
          checks++;
          if (active_ch_o !== 2'(e.ch)) begin
            errors++;
            $display("FAIL active_ch got=%0d expected=%0d", active_ch_o, e.ch);
          end
        end
      end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
        checks++;
        errors++;
        e = sb.pop_front();
        $display("FAIL missing_pulse ch=%0d expected at %0d, absent through %0d", e.ch, e.cyc, cyc);
      end
    end
    if (guard >= 5000) begin
      checks++;
      errors++;
      $display("FAIL run_until_budget cyc=%0d target=%0d", cyc, end_cyc);
    end
  endtask

  task automatic drain_check(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drained left=%0d expected=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    reset_i      = 1'b1;
    locked_i     = '0;
    running_i    = '0;
    resync_all_i = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_i      = 1'b1;
    locked_i     = '0;
    running_i    = '0;
    resync_all_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (resync_req_o !== '0) begin errors++; $display("FAIL reset_req got=%b expected=0000", resync_req_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b expected=0", busy_o); end
    checks++; if (active_ch_o !== 2'd3) begin errors++; $display("FAIL reset_active got=%0d expected=3", active_ch_o); end
    checks++; if (fault_o !== '0) begin errors++; $display("FAIL reset_fault got=%b expected=0000", fault_o); end
    reset_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy_o !== 1'b0 || resync_req_o !== '0) begin errors++; $display("FAIL idle_after_reset busy=%b req=%b expected 0/0000", busy_o, resync_req_o); end
  endtask

  task automatic test_single_lock();
    int t0;
    do_reset();
    t0 = cyc;
    locked_i  = 4'b0100;
    running_i = 4'b1111;
    push(2, t0 + 2);
    run_until(t0 + 1);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy_pending got=%b expected=1", busy_o); end
    run_until(t0 + SP);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy_last got=%b expected=1", busy_o); end
    run_until(t0 + SP + 1);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b expected=0", busy_o); end
    run_until(t0 + SP + 10);
    drain_check("single_lock");
  endtask

  task automatic test_round_robin();
    int t0;
    do_reset();
    t0 = cyc;
    locked_i     = 4'b1111;
    running_i    = 4'b1111;
    resync_all_i = 1'b1;
    for (int k = 0; k < NCH; k++) push(k, t0 + 2 + k * SP);
    run_until(t0 + 1);
    resync_all_i = 1'b0;
    run_until(t0 + 2 + 4 * SP);
    drain_check("rr_lock");
    t0 = cyc;
    resync_all_i = 1'b1;
    for (int k = 0; k < NCH; k++) push(k, t0 + 2 + k * SP);
    run_until(t0 + 1);
    resync_all_i = 1'b0;
    run_until(t0 + 2 + 4 * SP);
    drain_check("rr_all");
  endtask

  task automatic test_simultaneous();
    int t0;
    do_reset();
    running_i = 4'b1111;
    t0 = cyc;
    locked_i = 4'b0010;
    push(1, t0 + 2);
    run_until(t0 + SP + 2);
    locked_i = 4'b0000;
    run_until(cyc + 3);
    t0 = cyc;
    locked_i = 4'b1010;
    push(3, t0 + 2);
    push(1, t0 + 2 + SP);
    run_until(t0 + 2 + 2 * SP + 4);
    drain_check("simultaneous");
  endtask

  task automatic test_set_during_grant();
    int p;
    do_reset();
    locked_i  = 4'b0100;
    running_i = 4'b1111;
    p = cyc + 2;
    push(2, p);
    run_until(p);
    resync_all_i = 1'b1;
    push(2, p + SP);
    run_until(p + 1);
    resync_all_i = 1'b0;
    run_until(p + 2 * SP + 4);
    drain_check("set_during_grant");
  endtask

`ifdef ADAT_RESYNC_WATCHDOG_EN
  task automatic test_timeout();
    int p1;
    int p4;
    do_reset();
    running_i = 4'b0000;
    p1 = cyc + 2;
    locked_i = 4'b0001;
    for (int k = 0; k <= RETRIES; k++) push(0, p1 + k * (TMO + 1));
    p4 = p1 + RETRIES * (TMO + 1);
    run_until(p4 + TMO);
    checks++; if (fault_o !== 4'b0000) begin errors++; $display("FAIL timeout_fault_early got=%b expected=0000", fault_o); end
    run_until(p4 + TMO + 1);
    checks++; if (fault_o !== 4'b0001) begin errors++; $display("FAIL timeout_fault_set got=%b expected=0001", fault_o); end
    run_until(p4 + TMO + 1 + SETTLE + 20);
    drain_check("timeout");
    checks++; if (fault_o !== 4'b0001) begin errors++; $display("FAIL fault_sticky got=%b expected=0001", fault_o); end
    locked_i = 4'b0000;
    run_until(cyc + 2);
    checks++; if (fault_o !== 4'b0001) begin errors++; $display("FAIL fault_kept_on_unlock got=%b expected=0001", fault_o); end
    p1 = cyc;
    locked_i  = 4'b0001;
    running_i = 4'b0001;
    push(0, p1 + 2);
    run_until(p1 + 1);
    checks++; if (fault_o !== 4'b0000) begin errors++; $display("FAIL fault_clear got=%b expected=0000", fault_o); end
    run_until(p1 + 2 + SP + 4);
    drain_check("relock");
  endtask

  task automatic test_lock_loss();
    int p;
    do_reset();
    running_i = 4'b0000;
    p = cyc + 2;
    locked_i = 4'b0010;
    push(1, p);
    run_until(p + 1);
    locked_i = 4'b0000;
    run_until(p + 1 + SETTLE);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL lockloss_busy_settle got=%b expected=1", busy_o); end
    run_until(p + 2 + SETTLE);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL lockloss_idle got=%b expected=0", busy_o); end
    run_until(p + 2 + SETTLE + 30);
    checks++; if (fault_o !== 4'b0000) begin errors++; $display("FAIL lockloss_fault got=%b expected=0000", fault_o); end
    drain_check("lock_loss");
  endtask
`endif

  task automatic test_async_reset();
    int p;
    do_reset();
    running_i = 4'b1111;
    p = cyc + 2;
    locked_i = 4'b0100;
    push(2, p);
    run_until(p);
    locked_i = 4'b0000;
    reset_i  = 1'b1;
    #1;
    checks++; if (resync_req_o !== '0) begin errors++; $display("FAIL async_req got=%b expected=0000", resync_req_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL async_busy got=%b expected=0", busy_o); end
    checks++; if (active_ch_o !== 2'd3) begin errors++; $display("FAIL async_active got=%0d expected=3", active_ch_o); end
    checks++; if (fault_o !== '0) begin errors++; $display("FAIL async_fault got=%b expected=0000", fault_o); end
    @(negedge clk);
    reset_i = 1'b0;
    run_until(cyc + 10);
    drain_check("async_reset");
  endtask

  initial begin
    test_reset();
    test_single_lock();
    test_round_robin();
    test_simultaneous();
    test_set_during_grant();
`ifdef ADAT_RESYNC_WATCHDOG_EN
    test_timeout();
    test_lock_loss();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
